pkt_read_engine: RTL and testbench

Downstream neighbour of `MemController`: drains stored packets from packet memory and streams them to the next pipeline stage over a valid/ready interface. It accepts `{id, length}` descriptors once a packet has been fully written, queues them, and issues per-word `ren`/`r_id_in` reads to `MemController`. Returned words (`data_out`, `r_last_pkt`) go into a small output buffer. Read issue is credit-limited because the memory read path has no backpressure.

---
 rtl/pkt_read_engine_pkg.sv | 31 +++
 rtl/pkt_read_engine_if.sv | 25 ++
 rtl/pkt_sync_fifo.sv | 60 ++++++
 rtl/pkt_read_engine.sv | 151 +++++++++++++++
 tb/tb_pkt_read_engine.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_read_engine_pkg.sv
// -----------------------------------------------------------------------------
// pkt_rd_pkg
// Shared types for the packet read engine: FSM state encoding, default field
// widths, the descriptor record queued on write completion and the record
// stored per returned word in the output buffer.
// -----------------------------------------------------------------------------
package pkt_rd_pkg;

  localparam int DEF_ID_W   = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } state_t;

  // One stored packet waiting to be drained.
  typedef struct packed {
    logic [DEF_ID_W-1:0]  id;
    logic [DEF_LEN_W-1:0] len;
  } desc_t;

  // One word returned from packet memory, tagged with framing and ID.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic                  last;
    logic [DEF_ID_W-1:0]   id;
  } obuf_t;

endpackage

// File: rtl/pkt_read_engine_if.sv
// -----------------------------------------------------------------------------
// pkt_read_engine_if
// Valid/ready word stream leaving the packet read engine.
//   m_valid : word valid (source -> sink)
//   m_ready : sink accepts (sink -> source)
//   m_data  : word
//   m_last  : last word of packet
//   m_id    : packet ID of m_data
// Modports: master = stream source (the engine), slave = stream sink.
// -----------------------------------------------------------------------------
interface pkt_read_engine_if
  import pkt_rd_pkg::*;
#(
  parameter int ID_W   = DEF_ID_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic [ID_W-1:0]   m_id;

  modport master (output m_valid, output m_data, output m_last, output m_id, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, input m_id, output m_ready);
endinterface

// File: rtl/pkt_sync_fifo.sv
// -----------------------------------------------------------------------------
// pkt_sync_fifo
// Single-clock first-word-fall-through FIFO of an arbitrary packed type.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write one entry (ignored while full)
//   pop        : remove the head entry (ignored while empty)
//   rdata      : head entry, forced to zero while empty
//   full/empty : status flags
//   count      : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module pkt_sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  T                         wdata,
  input  logic                     pop,
  output T                         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == DEPTH[AW:0]);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Zero head while empty keeps the downstream bus at its reset value.
  assign rdata = empty ? T'('0) : mem[rd_ptr];

  // Storage carries no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/pkt_read_engine.sv
// -----------------------------------------------------------------------------
// pkt_read_engine
// Drains stored packets from packet memory and streams them downstream.
//   CLK, reset            : clock, asynchronous active-low reset
//   desc_push/id/len      : descriptor of a fully written packet
//   desc_full             : descriptor queue full
//   ren, r_id_in          : per-word read request to the memory controller
//   data_out, r_last_pkt  : read return, valid the cycle after ren
//   strm                  : valid/ready output word stream (master side)
//   err_ovf               : sticky, descriptor dropped (queue full or len=0)
//   err_len               : sticky, r_last_pkt disagreed with descriptor length
// The memory read path cannot be stalled, so reads are only issued while the
// output buffer has room for every word already requested.
// -----------------------------------------------------------------------------
module pkt_read_engine
  import pkt_rd_pkg::*;
#(
  parameter int ID_W       = DEF_ID_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int QDEPTH     = 16,
  parameter int OBUF_DEPTH = 4
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               desc_push,
  input  logic [ID_W-1:0]    desc_id,
  input  logic [LEN_W-1:0]   desc_len,
  output logic               desc_full,
  output logic               ren,
  output logic [ID_W-1:0]    r_id_in,
  input  logic [DATA_W-1:0]  data_out,
  input  logic               r_last_pkt,
  pkt_read_engine_if.master  strm,
  output logic               err_ovf,
  output logic               err_len
);
  localparam int QAW = $clog2(QDEPTH);
  localparam int OAW = $clog2(OBUF_DEPTH);
  localparam logic [OAW:0] OBUF_LIM = OBUF_DEPTH[OAW:0];

  state_t            state;
  logic [LEN_W-1:0]  words_left;
  logic              inflight;
  logic              inflight_last;
  logic [ID_W-1:0]   inflight_id;

  desc_t             q_in;
  desc_t             q_head;
  logic              q_push;
  logic              q_pop;
  logic              q_empty;
  logic [QAW:0]      q_count;

  obuf_t             obuf_in;
  obuf_t             obuf_head;
  logic              obuf_pop;
  logic              obuf_empty;
  logic              obuf_full;
  logic [OAW:0]      obuf_count;
  logic              credit_ok;
  logic              unused_status;

  // ---------------- descriptor queue ----------------
  assign q_in   = '{id: desc_id, len: desc_len};
  assign q_push = desc_push && (desc_len != '0);
  assign q_pop  = (state == S_IDLE) && !q_empty;

  pkt_sync_fifo #(.T(desc_t), .DEPTH(QDEPTH)) u_desc_q (
    .clk   (CLK),
    .rst_n (reset),
    .push  (q_push),
    .wdata (q_in),
    .pop   (q_pop),
    .rdata (q_head),
    .full  (desc_full),
    .empty (q_empty),
    .count (q_count)
  );

  // ---------------- credit and read issue ----------------
  // Credit counts the word in flight from last cycle's ren; a word leaving
  // the buffer this cycle is not credited until the count register updates.
  assign credit_ok = (obuf_count + {{OAW{1'b0}}, inflight}) < OBUF_LIM;
  // Decode of registered state only, so no input-to-output path.
  assign ren       = (state == S_READ) && credit_ok;

  // ---------------- FSM, read tags, sticky errors ----------------
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      r_id_in       <= '0;
      words_left    <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      inflight_id   <= '0;
      err_ovf       <= 1'b0;
      err_len       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!q_empty) begin
            r_id_in    <= q_head.id;
            words_left <= q_head.len;
            state      <= S_READ;
          end
        end
        S_READ: begin
          if (ren) begin
            words_left <= words_left - 1'b1;
            if (words_left == LEN_W'(1)) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Tag the request so the returned word knows its ID and framing even
      // after r_id_in has moved on to the next packet.
      inflight      <= ren;
      inflight_last <= (words_left == LEN_W'(1));
      inflight_id   <= r_id_in;

      if (desc_push && (desc_full || (desc_len == '0))) err_ovf <= 1'b1;
      if (inflight && (r_last_pkt != inflight_last))    err_len <= 1'b1;
    end
  end

  // ---------------- output buffer ----------------
  assign obuf_in  = '{data: data_out, last: inflight_last, id: inflight_id};
  assign obuf_pop = !obuf_empty && strm.m_ready;

  pkt_sync_fifo #(.T(obuf_t), .DEPTH(OBUF_DEPTH)) u_obuf (
    .clk   (CLK),
    .rst_n (reset),
    .push  (inflight),
    .wdata (obuf_in),
    .pop   (obuf_pop),
    .rdata (obuf_head),
    .full  (obuf_full),
    .empty (obuf_empty),
    .count (obuf_count)
  );

  assign strm.m_valid = !obuf_empty;
  assign strm.m_data  = obuf_head.data;
  assign strm.m_last  = obuf_head.last;
  assign strm.m_id    = obuf_head.id;

  // Status outputs not needed by this block.
  assign unused_status = &{1'b0, q_count, obuf_full};
endmodule

// File: tb/tb_pkt_read_engine.sv
// -----------------------------------------------------------------------------
// tb_pkt_read_engine
// Directed bench: a behavioural memory controller answers each ren one cycle
// later with 0xdeadface + word index and a configurable r_last_pkt position;
// accepted output words and issued reads are logged and compared against
// hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_pkt_read_engine;
  logic        CLK        = 1'b0;
  logic        reset      = 1'b0;
  logic        desc_push  = 1'b0;
  logic [3:0]  desc_id    = '0;
  logic [9:0]  desc_len   = '0;
  logic        desc_full;
  logic        ren;
  logic [3:0]  r_id_in;
  logic [31:0] data_out   = '0;
  logic        r_last_pkt = 1'b0;
  logic        err_ovf;
  logic        err_len;

  pkt_read_engine_if #(.ID_W(4), .DATA_W(32)) sif ();

  pkt_read_engine #(
    .ID_W(4), .DATA_W(32), .LEN_W(10), .QDEPTH(16), .OBUF_DEPTH(4)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .desc_push  (desc_push),
    .desc_id    (desc_id),
    .desc_len   (desc_len),
    .desc_full  (desc_full),
    .ren        (ren),
    .r_id_in    (r_id_in),
    .data_out   (data_out),
    .r_last_pkt (r_last_pkt),
    .strm       (sif),
    .err_ovf    (err_ovf),
    .err_len    (err_len)
  );

  always #5 CLK = ~CLK;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          t0       = 0;
  int          mv_first = -1;
  bit          junk_mode = 1'b0;
  int          word_cnt [16];
  int          last_at  [16];
  int          ren_cyc  [$];
  logic [3:0]  ren_id   [$];
  logic [31:0] got_data [$];
  logic        got_last [$];
  logic [3:0]  got_id   [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: log this cycle's activity, advance, then play memory.
  task automatic step();
    logic       rn;
    logic [3:0] rid;
    rn  = ren;
    rid = r_id_in;
    if (rn === 1'b1) begin
      ren_cyc.push_back(cyc);
      ren_id.push_back(rid);
    end
    if (sif.m_valid === 1'b1 && mv_first < 0) mv_first = cyc;
    if (sif.m_valid === 1'b1 && sif.m_ready === 1'b1) begin
      got_data.push_back(sif.m_data);
      got_last.push_back(sif.m_last);
      got_id.push_back(sif.m_id);
      $display("xfer cyc=%0d id=%0d data=%08h last=%0b", cyc, sif.m_id, sif.m_data, sif.m_last);
    end
    @(posedge CLK);
    cyc++;
    #1;
    if (rn === 1'b1) begin
      data_out   = 32'hdeadface + 32'(word_cnt[rid]);
      r_last_pkt = (word_cnt[rid] + 1 == last_at[rid]);
      word_cnt[rid]++;
    end else if (junk_mode) begin
      data_out   = 32'h12345678;
      r_last_pkt = 1'b1;
    end else begin
      data_out   = '0;
      r_last_pkt = 1'b0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_logs();
    ren_cyc.delete();
    ren_id.delete();
    got_data.delete();
    got_last.delete();
    got_id.delete();
    mv_first = -1;
    for (int i = 0; i < 16; i++) begin
      word_cnt[i] = 0;
      last_at[i]  = 0;
    end
  endtask

  task automatic push_desc(input logic [3:0] id, input logic [9:0] len);
    desc_id   = id;
    desc_len  = len;
    desc_push = 1'b1;
    step();
    desc_push = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run(2);
    reset = 1'b1;
    step();
  endtask

  initial begin
    sif.m_ready = 1'b0;
    clear_logs();
    #1;
    run(2);
    // ---------------- reset values ----------------
    check("rst_ren",      64'(ren),          64'(0));
    check("rst_r_id_in",  64'(r_id_in),      64'(0));
    check("rst_desc_full",64'(desc_full),    64'(0));
    check("rst_m_valid",  64'(sif.m_valid),  64'(0));
    check("rst_m_data",   64'(sif.m_data),   64'(0));
    check("rst_m_last",   64'(sif.m_last),   64'(0));
    check("rst_m_id",     64'(sif.m_id),     64'(0));
    check("rst_err_ovf",  64'(err_ovf),      64'(0));
    check("rst_err_len",  64'(err_len),      64'(0));
    reset = 1'b1;
    run(2);

    // ---------------- single packet {3,4} ----------------
    clear_logs();
    last_at[3]  = 4;
    sif.m_ready = 1'b1;
    t0 = cyc;
    push_desc(4'd3, 10'd4);
    run(10);
    check("t1_ren_cnt",   64'(ren_cyc.size()),   64'(4));
    check("t1_ren_first", 64'(ren_cyc[0] - t0),  64'(2));
    check("t1_ren_lastc", 64'(ren_cyc[3] - t0),  64'(5));
    check("t1_r_id_in0",  64'(ren_id[0]),        64'(3));
    check("t1_r_id_in3",  64'(ren_id[3]),        64'(3));
    check("t1_mv_first",  64'(mv_first - t0),    64'(4));
    check("t1_words",     64'(got_data.size()),  64'(4));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_data%0d", i), 64'(got_data[i]), 64'(32'hdeadface + 32'(i)));
      check($sformatf("t1_last%0d", i), 64'(got_last[i]), 64'(i == 3));
      check($sformatf("t1_id%0d", i),   64'(got_id[i]),   64'(3));
    end

    // ---------------- back-to-back {1,2} then {2,3} ----------------
    begin
      int         exp_off  [5] = '{2, 3, 5, 6, 7};
      logic [3:0] exp_id   [5] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd2};
      logic       exp_last [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      clear_logs();
      last_at[1] = 2;
      last_at[2] = 3;
      t0 = cyc;
      push_desc(4'd1, 10'd2);
      push_desc(4'd2, 10'd3);
      run(12);
      check("t2_ren_cnt", 64'(ren_cyc.size()),  64'(5));
      check("t2_words",   64'(got_data.size()), 64'(5));
      for (int i = 0; i < 5; i++) begin
        check($sformatf("t2_ren_off%0d", i), 64'(ren_cyc[i] - t0), 64'(exp_off[i]));
        check($sformatf("t2_m_id%0d", i),    64'(got_id[i]),       64'(exp_id[i]));
        check($sformatf("t2_m_last%0d", i),  64'(got_last[i]),     64'(exp_last[i]));
      end
      check("t2_data3",   64'(got_data[3]), 64'(32'hdeadfacf));
      check("t2_err_len", 64'(err_len),     64'(0));
    end

    // ---------------- backpressure {5,8} ----------------
    clear_logs();
    last_at[5]  = 8;
    sif.m_ready = 1'b0;
    push_desc(4'd5, 10'd8);
    run(10);
    check("t3_ren_cnt_stall", 64'(ren_cyc.size()), 64'(4));
    check("t3_ren_low",       64'(ren),            64'(0));
    check("t3_m_valid",       64'(sif.m_valid),    64'(1));
    check("t3_m_data_hold",   64'(sif.m_data),     64'(32'hdeadface));
    check("t3_m_id_hold",     64'(sif.m_id),       64'(5));
    check("t3_m_last_hold",   64'(sif.m_last),     64'(0));
    run(3);
    check("t3_ren_cnt_stall2",64'(ren_cyc.size()), 64'(4));
    check("t3_m_data_stable", 64'(sif.m_data),     64'(32'hdeadface));
    check("t3_no_xfer",       64'(got_data.size()),64'(0));
    sif.m_ready = 1'b1;
    run(20);
    check("t3_words", 64'(got_data.size()), 64'(8));
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_data%0d", i), 64'(got_data[i]), 64'(32'hdeadface + 32'(i)));
      check($sformatf("t3_last%0d", i), 64'(got_last[i]), 64'(i == 7));
    end

    // ---------------- descriptor queue full ----------------
    do_reset();
    clear_logs();
    sif.m_ready = 1'b0;
    last_at[9]  = 20;
    push_desc(4'd9, 10'd20);   // popped at once, then stalls on credit
    run(3);
    for (int i = 0; i < 16; i++) begin
      push_desc(4'(i), 10'd1);
      if (i == 14) check("t4_not_full_15", 64'(desc_full), 64'(0));
    end
    check("t4_full_16",    64'(desc_full), 64'(1));
    check("t4_ovf_before", 64'(err_ovf),   64'(0));
    push_desc(4'hA, 10'd1);
    check("t4_ovf_17",     64'(err_ovf),   64'(1));
    check("t4_full_17",    64'(desc_full), 64'(1));

    // ---------------- zero-length descriptor ----------------
    do_reset();
    check("t4_ovf_cleared", 64'(err_ovf), 64'(0));
    clear_logs();
    push_desc(4'd1, 10'd0);
    run(5);
    check("t4_ovf_len0",  64'(err_ovf),        64'(1));
    check("t4_len0_nord", 64'(ren_cyc.size()), 64'(0));

    // ---------------- length mismatch {7,3}, r_last_pkt on word 2 ----------------
    do_reset();
    clear_logs();
    sif.m_ready = 1'b1;
    last_at[7]  = 2;
    check("t5_err_len_pre", 64'(err_len), 64'(0));
    push_desc(4'd7, 10'd3);
    run(10);
    check("t5_err_len",  64'(err_len),         64'(1));
    check("t5_words",    64'(got_data.size()), 64'(3));
    check("t5_last0",    64'(got_last[0]),     64'(0));
    check("t5_last1",    64'(got_last[1]),     64'(0));
    check("t5_last2",    64'(got_last[2]),     64'(1));
    check("t5_data2",    64'(got_data[2]),     64'(32'hdeadfad0));

    // ---------------- reset mid-packet {4,6} ----------------
    do_reset();
    clear_logs();
    last_at[4] = 6;
    push_desc(4'd4, 10'd6);
    run(3);
    check("t6_pre_m_valid", 64'(sif.m_valid), 64'(1));
    reset = 1'b0;
    #1;
    check("t6_ren",       64'(ren),         64'(0));
    check("t6_r_id_in",   64'(r_id_in),     64'(0));
    check("t6_m_valid",   64'(sif.m_valid), 64'(0));
    check("t6_m_data",    64'(sif.m_data),  64'(0));
    check("t6_m_id",      64'(sif.m_id),    64'(0));
    check("t6_m_last",    64'(sif.m_last),  64'(0));
    check("t6_err_ovf",   64'(err_ovf),     64'(0));
    check("t6_err_len",   64'(err_len),     64'(0));
    run(2);
    clear_logs();
    reset     = 1'b1;
    junk_mode = 1'b1;
    data_out  = 32'h12345678;
    r_last_pkt = 1'b1;
    run(2);
    junk_mode = 1'b0;
    run(4);
    check("t6_no_stray_mv", 64'(mv_first),        64'(-1));
    check("t6_no_words",    64'(got_data.size()), 64'(0));
    check("t6_err_len_post",64'(err_len),         64'(0));
    last_at[4] = 1;
    push_desc(4'd4, 10'd1);
    run(8);
    check("t6_new_words", 64'(got_data.size()), 64'(1));
    check("t6_new_data",  64'(got_data[0]),     64'(32'hdeadface));
    check("t6_new_last",  64'(got_last[0]),     64'(1));
    check("t6_new_id",    64'(got_id[0]),       64'(4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
